alu_byte_sequencer: RTL

- Initiator side of the ALU top's load interface: takes a byte stream from the UART receiver (A, B, opcode, in that order) and drives the ALU's data bus and three load strobes.
- After the operation it samples the ALU result and hands it to the UART transmitter as one byte.
- Sits between uart_rx/uart_tx and the ALU top; replaces the board switches and buttons.

---
 rtl/alu_byte_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/alu_byte_sequencer.sv
// rtl/alu_byte_sequencer.sv - UART byte stream to ALU load strobes and result byte (optional macro: ALU_SEQ_OPCODE_CHECK_EN)
module alu_byte_sequencer #(
    parameter int N_BITS       = 8,
    parameter int LATCH_CYCLES = 2,
    parameter int RESULT_WAIT  = 1
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic [N_BITS-1:0] i_rx_data,
    input  logic              i_rx_done,
    output logic [N_BITS-1:0] o_data_bus,
    output logic              o_bt_1,
    output logic              o_bt_2,
    output logic              o_bt_3,
    input  logic [N_BITS-1:0] i_leds,
    output logic [N_BITS-1:0] o_tx_data,
    output logic              o_tx_start,
    input  logic              i_tx_done,
    output logic              o_busy,
    output logic              o_overrun
);

    localparam int CW = 16;

    typedef enum logic [3:0] {
        WAIT_A,
        LOAD_A,
        WAIT_B,
        LOAD_B,
        WAIT_OP,
        LOAD_OP,
        SETTLE,
        SEND,
        WAIT_TX
    } state_t;

    state_t            state, state_next;
    logic [CW-1:0]     cnt, cnt_next;
    logic [N_BITS-1:0] bus_next;
    logic [N_BITS-1:0] tx_data_next;
    logic              tx_start_next;
    logic              accepting;

`ifdef ALU_SEQ_OPCODE_CHECK_EN
    logic opcode_ok;

    // Only the eight supported function codes may reach the ALU
    always_comb begin
        opcode_ok = 1'b0;
        case (i_rx_data[5:0])
            6'h20, 6'h22, 6'h24, 6'h25,
            6'h26, 6'h27, 6'h03, 6'h02: opcode_ok = 1'b1;
            default:                    opcode_ok = 1'b0;
        endcase
    end
`endif

    // State, counter and registered outputs; reset aborts any sequence in flight
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= WAIT_A;
            cnt        <= '0;
            o_data_bus <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            o_data_bus <= bus_next;
            o_tx_data  <= tx_data_next;
            o_tx_start <= tx_start_next;
        end
    end

    // Next-state logic plus strobes decoded from the current state
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        bus_next      = o_data_bus;
        tx_data_next  = o_tx_data;
        tx_start_next = 1'b0;
        o_bt_1        = 1'b0;
        o_bt_2        = 1'b0;
        o_bt_3        = 1'b0;
        o_busy        = (state != WAIT_A);
        // Bytes are only taken while waiting for one; anything else is dropped
        accepting     = (state == WAIT_A) || (state == WAIT_B) || (state == WAIT_OP);
        o_overrun     = i_rx_done && !accepting;

        case (state)
            WAIT_A: begin
                if (i_rx_done) begin
                    bus_next   = i_rx_data;
                    cnt_next   = '0;
                    state_next = LOAD_A;
                end
            end
            LOAD_A: begin
                o_bt_1 = 1'b1;
                if (cnt == CW'(LATCH_CYCLES - 1)) begin
                    cnt_next   = '0;
                    state_next = WAIT_B;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    bus_next   = i_rx_data;
                    cnt_next   = '0;
                    state_next = LOAD_B;
                end
            end
            LOAD_B: begin
                o_bt_2 = 1'b1;
                if (cnt == CW'(LATCH_CYCLES - 1)) begin
                    cnt_next   = '0;
                    state_next = WAIT_OP;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    cnt_next = '0;
`ifdef ALU_SEQ_OPCODE_CHECK_EN
                    if (opcode_ok) begin
                        bus_next   = N_BITS'(i_rx_data[5:0]);
                        state_next = LOAD_OP;
                    end else begin
                        tx_data_next = '1;
                        state_next   = SEND;
                    end
`else
                    bus_next   = N_BITS'(i_rx_data[5:0]);
                    state_next = LOAD_OP;
`endif
                end
            end
            LOAD_OP: begin
                o_bt_3 = 1'b1;
                if (cnt == CW'(LATCH_CYCLES - 1)) begin
                    cnt_next   = '0;
                    state_next = SETTLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            SETTLE: begin
                if (cnt == CW'(RESULT_WAIT - 1)) begin
                    cnt_next     = '0;
                    tx_data_next = i_leds;
                    state_next   = SEND;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            SEND: begin
                tx_start_next = 1'b1;
                state_next    = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    state_next = WAIT_A;
                end
            end
            default: begin
                state_next = WAIT_A;
            end
        endcase
    end

endmodule
